// File: rtl/xtable_arbiter.sv
// ---------------------------------------------------------------------------
// xtable_arbiter
//
// Two-port front end for the single-port 8x8 times-table ROM (mem_xtable,
// 64 x 6-bit, address = {a,b}). It arbitrates round-robin between two
// requesters, drives the ROM enable/address from registers, and follows every
// read through the fixed ROM latency. When the read completes it returns the
// ROM word to the requester that issued it.
//
// Parameters
//   MEM_LAT   ROM read latency in cycles (1..4). This is the time from the edge
//             that samples mem_en/mem_addr to mem_dout being valid.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-high reset
//   req0/req1           requests; operands are held stable until granted
//   a0,b0 / a1,b1       3-bit operands for requester 0 / 1
//   gnt0/gnt1           combinational accept, high in the cycle the request
//                       is taken
//   valid0/valid1       one-cycle pulse when result0/result1 is updated
//   result0/result1     registered product; holds between pulses
//   mem_en/mem_addr     registered ROM enable / address (ena / addra)
//   mem_dout            ROM read data (douta)
//   err                 sticky self-check flag
//
// Optional feature
//   XTABLE_CHECK_EN     When defined, the tag pipeline also carries the
//                       operands. Each returned ROM word is compared with a*b,
//                       and err is set on a mismatch. When undefined, err is
//                       tied low.
//
// Timing: a grant in cycle T gives mem_en/mem_addr in T+1 and ROM data in
// T+1+MEM_LAT. valid/result are visible in T+2+MEM_LAT.
// ---------------------------------------------------------------------------
module xtable_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] a0,
    input  logic [2:0] b0,
    input  logic [2:0] a1,
    input  logic [2:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       valid0,
    output logic       valid1,
    output logic [5:0] result0,
    output logic [5:0] result1,
    output logic       mem_en,
    output logic [5:0] mem_addr,
    input  logic [5:0] mem_dout,
    output logic       err
);

    // Round-robin pointer: index of the most recently granted requester.
    logic       last_r;

    // Arbitration results for the current cycle.
    logic       gnt0_s;
    logic       gnt1_s;
    logic       any_gnt_s;
    logic       gnt_idx_s;
    logic [2:0] sel_a_s;
    logic [2:0] sel_b_s;

    // Registered ROM interface.
    logic       mem_en_r;
    logic [5:0] mem_addr_r;

    // Tag pipeline. The last stage lines up with the cycle in which mem_dout
    // carries the data for that tag.
    logic       tag_vld_r [0:MEM_LAT];
    logic       tag_idx_r [0:MEM_LAT];

    // Tag at the pipeline output.
    logic       out_vld_s;
    logic       out_idx_s;

    // Registered return ports.
    logic       valid0_r;
    logic       valid1_r;
    logic [5:0] result0_r;
    logic [5:0] result1_r;

`ifdef XTABLE_CHECK_EN
    // Operands travel with the tag so the returned word can be re-checked.
    logic [2:0] tag_a_r [0:MEM_LAT];
    logic [2:0] tag_b_r [0:MEM_LAT];
    logic       err_r;

    // Reference product at 6-bit width. The largest value is 49, which fits.
    function automatic logic [5:0] xt_product(input logic [2:0] a, input logic [2:0] b);
        logic [5:0] p;
        p = {3'b000, a} * {3'b000, b};
        return p;
    endfunction
`endif

    // Arbiter: a single request wins outright. On a tie the requester other
    // than last_r wins.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (req0 && req1) begin
            if (last_r) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (req0) begin
            gnt0_s = 1'b1;
        end else if (req1) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Operand and index mux for the granted requester.
    always_comb begin
        sel_a_s   = a0;
        sel_b_s   = b0;
        gnt_idx_s = 1'b0;
        if (gnt1_s) begin
            sel_a_s   = a1;
            sel_b_s   = b1;
            gnt_idx_s = 1'b1;
        end else begin
            sel_a_s   = a0;
            sel_b_s   = b0;
            gnt_idx_s = 1'b0;
        end
    end

    assign any_gnt_s = gnt0_s | gnt1_s;

    // Round-robin pointer update. It resets to 1 so requester 0 wins the
    // first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (any_gnt_s) begin
            last_r <= gnt_idx_s;
        end else begin
            last_r <= last_r;
        end
    end

    // ROM enable/address registers. The address holds on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_r   <= 1'b0;
            mem_addr_r <= 6'd0;
        end else if (any_gnt_s) begin
            mem_en_r   <= 1'b1;
            mem_addr_r <= {sel_a_s, sel_b_s};
        end else begin
            mem_en_r   <= 1'b0;
            mem_addr_r <= mem_addr_r;
        end
    end

    // Tag shift register. A null tag enters on idle cycles. Reset drops every
    // in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= MEM_LAT; k++) begin
                tag_vld_r[k] <= 1'b0;
                tag_idx_r[k] <= 1'b0;
            end
        end else begin
            tag_vld_r[0] <= any_gnt_s;
            tag_idx_r[0] <= gnt_idx_s;
            for (int k = 1; k <= MEM_LAT; k++) begin
                tag_vld_r[k] <= tag_vld_r[k-1];
                tag_idx_r[k] <= tag_idx_r[k-1];
            end
        end
    end

`ifdef XTABLE_CHECK_EN
    // Operand pipeline alongside the tags, used only by the self-check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= MEM_LAT; k++) begin
                tag_a_r[k] <= 3'd0;
                tag_b_r[k] <= 3'd0;
            end
        end else begin
            tag_a_r[0] <= sel_a_s;
            tag_b_r[0] <= sel_b_s;
            for (int k = 1; k <= MEM_LAT; k++) begin
                tag_a_r[k] <= tag_a_r[k-1];
                tag_b_r[k] <= tag_b_r[k-1];
            end
        end
    end
`endif

    assign out_vld_s = tag_vld_r[MEM_LAT];
    assign out_idx_s = tag_idx_r[MEM_LAT];

    // Result return: capture mem_dout for the owning requester only. valid
    // is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid0_r  <= 1'b0;
            valid1_r  <= 1'b0;
            result0_r <= 6'd0;
            result1_r <= 6'd0;
        end else begin
            valid0_r <= 1'b0;
            valid1_r <= 1'b0;
            if (out_vld_s) begin
                if (out_idx_s == 1'b0) begin
                    valid0_r  <= 1'b1;
                    result0_r <= mem_dout;
                end else begin
                    valid1_r  <= 1'b1;
                    result1_r <= mem_dout;
                end
            end else begin
                result0_r <= result0_r;
                result1_r <= result1_r;
            end
        end
    end

`ifdef XTABLE_CHECK_EN
    // Sticky mismatch flag. Only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (out_vld_s &&
                     (mem_dout != xt_product(tag_a_r[MEM_LAT], tag_b_r[MEM_LAT]))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign gnt0     = gnt0_s;
    assign gnt1     = gnt1_s;
    assign mem_en   = mem_en_r;
    assign mem_addr = mem_addr_r;
    assign valid0   = valid0_r;
    assign valid1   = valid1_r;
    assign result0  = result0_r;
    assign result1  = result1_r;

endmodule

// File: tb/tb_xtable_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xtable_arbiter
//
// Directed bench for xtable_arbiter. It uses two instances:
//   u_dut   MEM_LAT=1 with a 1-cycle ROM model. The ROM model can corrupt
//           address 63 to 0.
//   u_dut2  MEM_LAT=2 with a 2-cycle ROM model.
// Inputs are driven just after the falling edge and checked 1 time unit later.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_xtable_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req0 = 1'b0, req1 = 1'b0;
    logic [2:0] a0 = 3'd0, b0 = 3'd0, a1 = 3'd0, b1 = 3'd0;
    logic       gnt0, gnt1, valid0, valid1, mem_en, err;
    logic [5:0] result0, result1, mem_addr, mem_dout;
    logic       corrupt = 1'b0;

    logic       req0b = 1'b0, req1b = 1'b0;
    logic [2:0] a0b = 3'd0, b0b = 3'd0, a1b = 3'd0, b1b = 3'd0;
    logic       gnt0b, gnt1b, valid0b, valid1b, mem_enb, errb;
    logic [5:0] result0b, result1b, mem_addrb, mem_doutb, rom2_stage;

    int checks = 0;
    int errors = 0;

`ifdef XTABLE_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic [5:0] prod_tab [8];

    always #5 clk = ~clk;

    xtable_arbiter #(.MEM_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1),
        .result0(result0), .result1(result1),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout), .err(err)
    );

    xtable_arbiter #(.MEM_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .req0(req0b), .req1(req1b),
        .a0(a0b), .b0(b0b), .a1(a1b), .b1(b1b),
        .gnt0(gnt0b), .gnt1(gnt1b), .valid0(valid0b), .valid1(valid1b),
        .result0(result0b), .result1(result1b),
        .mem_en(mem_enb), .mem_addr(mem_addrb), .mem_dout(mem_doutb), .err(errb)
    );

    function automatic logic [5:0] rom_word(input logic [5:0] addr);
        logic [5:0] aa, bb;
        aa = {3'b000, addr[5:3]};
        bb = {3'b000, addr[2:0]};
        return aa * bb;
    endfunction

    // 1-cycle ROM with an optional fault at address 63.
    always @(posedge clk) begin
        if (mem_en) begin
            if (corrupt && (mem_addr == 6'd63)) begin
                mem_dout <= 6'd0;
            end else begin
                mem_dout <= rom_word(mem_addr);
            end
        end
    end

    // 2-cycle ROM.
    always @(posedge clk) begin
        if (mem_enb) begin
            rom2_stage <= rom_word(mem_addrb);
        end
        mem_doutb <= rom2_stage;
    end

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        prod_tab = '{6'd0, 6'd5, 6'd6, 6'd15, 6'd12, 6'd25, 6'd18, 6'd35};

        // Reset values
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_valid0", valid0, 1'b0);
        chk1("rst_valid1", valid1, 1'b0);
        chk6("rst_result0", result0, 6'd0);
        chk6("rst_result1", result1, 6'd0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk6("rst_mem_addr", mem_addr, 6'd0);
        chk1("rst_err", err, 1'b0);

        // Single request 3*5
        cyc(); req0 = 1'b1; a0 = 3'd3; b0 = 3'd5; #1;
        chk1("t1_gnt0", gnt0, 1'b1);
        chk1("t1_gnt1", gnt1, 1'b0);
        cyc(); req0 = 1'b0; #1;
        chk1("t1_mem_en", mem_en, 1'b1);
        chk6("t1_mem_addr", mem_addr, 6'd29);
        cyc(); #1;
        chk1("t1_valid0_early", valid0, 1'b0);
        chk1("t1_mem_en_idle", mem_en, 1'b0);
        chk6("t1_mem_addr_hold", mem_addr, 6'd29);
        cyc(); #1;
        chk1("t1_valid0", valid0, 1'b1);
        chk6("t1_result0", result0, 6'd15);
        chk1("t1_valid1", valid1, 1'b0);
        cyc(); #1;
        chk1("t1_valid0_pulse", valid0, 1'b0);
        chk6("t1_result0_hold", result0, 6'd15);

        // Tie after reset
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        cyc(); req0 = 1'b1; req1 = 1'b1; a0 = 3'd2; b0 = 3'd3; a1 = 3'd7; b1 = 3'd7; #1;
        chk1("t2_gnt0", gnt0, 1'b1);
        chk1("t2_gnt1_blocked", gnt1, 1'b0);
        cyc(); req0 = 1'b0; #1;
        chk1("t2_gnt1", gnt1, 1'b1);
        chk1("t2_gnt0_off", gnt0, 1'b0);
        chk6("t2_mem_addr0", mem_addr, 6'd19);
        cyc(); req1 = 1'b0; #1;
        chk6("t2_mem_addr1", mem_addr, 6'd63);
        cyc(); #1;
        chk1("t2_valid0", valid0, 1'b1);
        chk6("t2_result0", result0, 6'd6);
        chk1("t2_valid1_early", valid1, 1'b0);
        cyc(); #1;
        chk1("t2_valid1", valid1, 1'b1);
        chk6("t2_result1", result1, 6'd49);
        chk1("t2_valid0_off", valid0, 1'b0);

        // Both held for 8 cycles: alternation and back-to-back returns
        for (int c = 0; c < 11; c++) begin
            cyc();
            if (c < 8) begin
                req0 = 1'b1; req1 = 1'b1;
                a0 = c[2:0]; b0 = 3'd3; a1 = c[2:0]; b1 = 3'd5;
            end else begin
                req0 = 1'b0; req1 = 1'b0;
            end
            #1;
            if (c < 8) begin
                chk1("t3_gnt0", gnt0, (c % 2) == 0);
                chk1("t3_gnt1", gnt1, (c % 2) == 1);
            end
            if (c >= 3) begin
                chk1("t3_valid0", valid0, ((c - 3) % 2) == 0);
                chk1("t3_valid1", valid1, ((c - 3) % 2) == 1);
                if (((c - 3) % 2) == 0) begin
                    chk6("t3_result0", result0, prod_tab[c-3]);
                end else begin
                    chk6("t3_result1", result1, prod_tab[c-3]);
                end
            end
        end

        // Reset one cycle after a grant of 4*4
        cyc(); req0 = 1'b1; a0 = 3'd4; b0 = 3'd4; #1;
        chk1("t4_gnt0", gnt0, 1'b1);
        cyc(); req0 = 1'b0; rst = 1'b1; #1;
        chk1("t4_mem_en", mem_en, 1'b0);
        chk6("t4_mem_addr", mem_addr, 6'd0);
        chk6("t4_result0", result0, 6'd0);
        chk6("t4_result1", result1, 6'd0);
        chk1("t4_valid0", valid0, 1'b0);
        chk1("t4_err", err, 1'b0);
        cyc(); rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc(); #1;
            chk1("t4_no_valid0", valid0, 1'b0);
            chk1("t4_no_valid1", valid1, 1'b0);
        end

        // MEM_LAT=2 instance: 6*7 on requester 1
        cyc(); req1b = 1'b1; a1b = 3'd6; b1b = 3'd7; #1;
        chk1("t5_gnt1", gnt1b, 1'b1);
        cyc(); req1b = 1'b0; #1;
        chk1("t5_mem_en", mem_enb, 1'b1);
        chk6("t5_mem_addr", mem_addrb, 6'd55);
        cyc(); #1;
        chk1("t5_valid1_t2", valid1b, 1'b0);
        cyc(); #1;
        chk1("t5_valid1_t3", valid1b, 1'b0);
        cyc(); #1;
        chk1("t5_valid1", valid1b, 1'b1);
        chk6("t5_result1", result1b, 6'd42);
        chk1("t5_valid0", valid0b, 1'b0);

        // Corrupted ROM word at address 63
        corrupt = 1'b1;
        cyc(); req0 = 1'b1; a0 = 3'd7; b0 = 3'd7; #1;
        chk1("t6_gnt0", gnt0, 1'b1);
        cyc(); req0 = 1'b0; #1;
        chk6("t6_mem_addr", mem_addr, 6'd63);
        cyc(); #1;
        chk1("t6_err_early", err, 1'b0);
        cyc(); #1;
        chk1("t6_valid0", valid0, 1'b1);
        chk6("t6_result0", result0, 6'd0);
        chk1("t6_err", err, EXP_ERR);
        cyc(); cyc(); #1;
        chk1("t6_err_sticky", err, EXP_ERR);
        cyc(); rst = 1'b1; #1;
        chk1("t6_err_cleared", err, 1'b0);
        cyc(); rst = 1'b0;
        corrupt = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xtable_arbiter.md
# xtable_arbiter

Two-port controller for the single-port 0..7 x 0..7 times-table ROM (`mem_xtable`, 64 x 6-bit, address = a*8 + b). It arbitrates round-robin between two requesters and drives the ROM's enable and address. It tracks each read through the ROM's fixed read latency and returns the 6-bit product to the requester that issued it. It sits between the ROM instance and the user logic; it does not replace the ROM.

## Interface
- `MEM_LAT`, default 1: ROM read latency in cycles, from the edge sampling `mem_en`/`mem_addr` to `mem_dout` valid. Legal values are 1..4.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req0`, `req1`  in  1  request from requester 0 or 1; held high with operands stable until granted.
- `a0`, `b0`, `a1`, `b1`  in  3 each  operands for requester 0 and requester 1.
- `gnt0`, `gnt1`  out  1 each  combinational accept; high in the cycle the request is taken.
- `valid0`, `valid1`  out  1 each  one-cycle pulse; `result` holds the product for that requester.
- `result0`, `result1`  out  6 each  registered product, 0..49; holds its value between pulses.
- `mem_en`  out  1  registered ROM enable (drives `ena`).
- `mem_addr`  out  6  registered ROM address (drives `addra`).
- `mem_dout`  in  6  ROM data (from `douta`).
- `err`  out  1  sticky self-check flag (see Configuration).

## Operation
- Arbitration is combinational from `req0`, `req1` and the 1-bit pointer `last`. At most one grant is high per cycle.
    - Only one request high: that requester is granted.
    - Both high: the requester not equal to `last` is granted.
    - `last` updates to the granted index on any grant.
    - Reset value of `last` is 1, so requester 0 wins the first tie.
- On a grant edge:
    - `mem_en` is set to 1.
    - `mem_addr` is set to {a,b} of the granted requester.
    - A tag (valid bit, requester index) enters a shift register of depth MEM_LAT+1.
- On a no-grant edge: `mem_en` is set to 0; `mem_addr` holds its value; a null tag enters the shift register.
- When the tag emerges, `mem_dout` is captured into `result<idx>` and `valid<idx>` pulses for one cycle. The other requester's result and valid are untouched.
- Fully pipelined: one grant per cycle, no stall, no limit on outstanding reads. Results return in grant order.
- The requester may raise a new `req` with new operands in the cycle after `gnt`. Keeping `req` high after `gnt` is treated as a new request.
- No datapath arithmetic: the address is concatenation only and the product comes from the ROM.
- Reset mid-operation:
    - All in-flight tags are discarded; no `valid` pulses for them after reset release.
    - `mem_en`, `mem_addr`, all `valid`, all `result` and `err` go to 0 immediately.

## Timing
- Cycle T: `req` high and `gnt` high (same cycle).
- Cycle T+1: `mem_en`=1, `mem_addr` valid.
- Cycle T+1+MEM_LAT: `mem_dout` valid.
- Cycle T+2+MEM_LAT: `valid`/`result` present. With the default MEM_LAT=1 this is 3 cycles after grant.
- Reset values: `gnt*`=0 (while `req*`=0), `valid*`=0, `result*`=0, `mem_en`=0, `mem_addr`=0, `err`=0, `last`=1.
- Simultaneous grant and result return in the same cycle is normal pipelined operation; both occur.

## Configuration
- Macro `XTABLE_CHECK_EN`, defined:
    - The tag pipeline also carries a and b.
    - At capture, the ROM data is compared with a*b computed at 6-bit width.
    - On mismatch, `err` is set and stays set until `rst`.
- Macro `XTABLE_CHECK_EN`, not defined: operands are not carried, `err` is tied to 0, and the port list is unchanged.

## Test plan
- Single request: `req0`, a0=3, b0=5 at T -> `gnt0` at T; `mem_addr`=29, `mem_en`=1 at T+1; `valid0`=1, `result0`=15 at T+3; `valid1` stays 0.
- Tie after reset: both requests at T with a0=2, b0=3 and a1=7, b1=7 -> `gnt0` at T, `gnt1` at T+1; `result0`=6 at T+3; `result1`=49 at T+4.
- Both requesters held high for 8 cycles -> grants alternate 0,1,0,1…; one `valid` per cycle from T+3; results match the operand order.
- Assert `rst` one cycle after a grant with a=4, b=4 -> outputs 0 at once; no `valid` pulse follows the release.
- MEM_LAT=2: a1=6, b1=7 -> `result1`=42 with `valid1` at T+4.
- `XTABLE_CHECK_EN` defined, ROM model corrupted at address 63 to 0: request a=7, b=7 -> `err`=1 at T+3 and remains 1 until `rst`. Macro undefined, same stimulus -> `err`=0.
